axis_shift_arbiter: RTL and testbench
=====================================

AXIS_SHIFT_ARBITER -- requirements
Module: axis_shift_arbiter

Interface
REQ-001 SHALL use one clock (aclk); reset ARESET is synchronous, active-high.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, meaning the tdata width in bits (multiple of 8).
REQ-003 SHALL have parameter N_SRC, default 4, meaning the number of requesting AXI4-stream sources (2..8).
REQ-004 SHALL have parameter MAX_BEATS, default 16, meaning the maximum beats per packet before forced termination.
REQ-005 SHALL have derived constants SHIFT_W = clog2(BUS_WIDTH/8) and ID_W = clog2(N_SRC).
REQ-006 SHALL have these ports (name, direction, width, meaning):
- aclk  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- s_tdata  in  N_SRC*BUS_WIDTH  packed source data; source i occupies slice i.
- s_tvalid  in  N_SRC  per-source valid.
- s_tlast  in  N_SRC  per-source last.
- s_tready  out  N_SRC  per-source ready.
- m_tdata  out  BUS_WIDTH  data to the shared byte shifter.
- m_tvalid  out  1  shifter-side valid.
- m_tlast  out  1  shifter-side last.
- m_tready  in  1  shifter-side ready.
- m_shift_bytes  out  SHIFT_W  shift amount for the current packet.
- m_src_id  out  ID_W  granted source index.
- cfg_we  in  1  shift-table write strobe.
- cfg_addr  in  ID_W  shift-table entry.
- cfg_shift  in  SHIFT_W  shift value to write.
- err_overlen  out  1  sticky over-length flag.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, XFER and DROP.
REQ-008 In IDLE with any s_tvalid high: SHALL pick a source round-robin, searching from rr_ptr+1 upward with wrap; SHALL register the grant, m_src_id, and m_shift_bytes = shift_table[grant]; SHALL set rr_ptr = grant; SHALL go to XFER next cycle.
REQ-009 In IDLE: SHALL hold all s_tready and m_tvalid at 0.
REQ-010 In XFER: SHALL drive m_tdata = slice[grant], m_tvalid = s_tvalid[grant], m_tlast = s_tlast[grant] OR forced-last, s_tready[grant] = m_tready; all other s_tready SHALL be 0. The path is combinational: zero-cycle latency and full throughput.
REQ-011 SHALL count beats in a beat counter when m_tvalid and m_tready are both high; the counter clears on grant.
REQ-012 On an accepted beat with s_tlast[grant]=1: SHALL go to IDLE. The next grant is decided in that IDLE cycle, which gives exactly one bubble cycle between packets.
REQ-013 On accepted beat number MAX_BEATS with s_tlast[grant]=0: SHALL force m_tlast=1 on that beat, set err_overlen, and go to DROP.
REQ-014 If beat MAX_BEATS itself carries s_tlast: SHALL treat it as a normal end (no error; go to IDLE).
REQ-015 In DROP: SHALL drive s_tready[grant]=1 and m_tvalid=0, discarding beats; on an accepted beat with s_tlast[grant]=1, SHALL go to IDLE.
REQ-016 m_shift_bytes and m_src_id SHALL stay stable from grant until the return to IDLE.
REQ-017 cfg_we SHALL update shift_table[cfg_addr] at the clock edge. A write to the granted entry mid-packet SHALL affect only subsequent packets.
REQ-018 A cfg write in the same cycle as a grant of the same entry: the grant SHALL use the old value.
REQ-019 A source that drops s_tvalid mid-packet SHALL keep the grant (no timeout); the arbiter SHALL wait in XFER.
REQ-020 err_overlen SHALL clear only on ARESET.

Reset
REQ-021 ARESET SHALL force: state=IDLE, rr_ptr=N_SRC-1 (source 0 has first priority), beat counter=0, shift_table all 0, m_src_id=0, m_shift_bytes=0, err_overlen=0, and outputs m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, busy=0.
REQ-022 ARESET asserted mid-packet SHALL abandon the packet with no further beats issued, and SHALL take priority over cfg_we in the same cycle.

Structure
REQ-023 Package axis_shift_pkg SHALL hold the FSM state encoding, the BUS_WIDTH default, and a clog2 helper for SHIFT_W/ID_W.
REQ-024 The round-robin pick SHALL be a combinational sub-module, axis_rr_pick (inputs: request vector, rr_ptr; outputs: grant index, any-request).

Verification
REQ-025 Reset, then source 0 and source 2 request together -> source 0 granted first (m_src_id=0); after its tlast, source 2 is granted after one bubble cycle.
REQ-026 All 4 sources stream 3-beat packets continuously -> grant order 0,1,2,3,0, with 12 beats per round and no source starved.
REQ-027 cfg write shift_table[1]=3, then source 1 sends a packet -> m_shift_bytes=3 for all beats; a write of 1 mid-packet does not change it until the next packet.
REQ-028 Source 3 sends 20 beats with MAX_BEATS=16 -> beat 16 has m_tlast=1, err_overlen=1, beats 17-20 are dropped (m_tvalid=0, s_tready[3]=1), then the FSM returns to IDLE.
REQ-029 m_tready toggles 1,0,0,1 during a 4-beat packet with data 32'h11111111..32'h44444444 -> all 4 words appear in order with none lost or duplicated.
REQ-030 ARESET asserted on beat 2 of 5 -> next cycle busy=0 and all s_tready=0; after release, source 0 has first priority.

Source files
------------

// File: rtl/axis_shift_pkg.sv
// Shared definitions for the AXI4-stream shift arbiter.
//   state_e        : arbiter FSM state encoding (IDLE / XFER / DROP)
//   BUS_WIDTH_DEF  : default tdata width in bits
//   clog2()        : ceiling log2, never below 1 so derived widths stay legal
package axis_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam int BUS_WIDTH_DEF = 32;

    // Clamped to 1 so an 8-bit bus or a degenerate count still yields a
    // one-bit field instead of a zero-width vector.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per source
//   ptr_i   : last granted index; search starts at ptr_i+1 and wraps
//   grant_o : first requesting index found (0 when nothing requests)
//   any_o   : at least one request is present
module axis_rr_pick
    import axis_shift_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  grant_o,
    output logic             any_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        any_o   = |req_i;
        found   = 1'b0;
        idx     = 0;
        // k runs to N_SRC so the previously granted source is checked last.
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(ptr_i) + k) % N_SRC;
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                grant_o = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axis_shift_arbiter.sv
// Arbitrates N_SRC AXI4-stream sources onto one shared byte-shifter port.
// A source holds the grant for a whole packet; each packet carries the
// shift amount latched from a small per-source table at grant time.
// Packets longer than MAX_BEATS are cut with a forced tlast, the rest of
// the packet is swallowed, and a sticky error is raised.
//   aclk, ARESET                 : clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast     : packed source streams (slice i = source i)
//   s_tready                     : per-source ready
//   m_tdata/m_tvalid/m_tlast     : shifter-side stream, m_tready back-pressure
//   m_shift_bytes, m_src_id      : per-packet shift amount and granted source
//   cfg_we/cfg_addr/cfg_shift    : shift-table write port
//   err_overlen                  : sticky over-length flag
//   busy                         : FSM not in IDLE
module axis_shift_arbiter
    import axis_shift_pkg::*;
#(
    parameter int  BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int  N_SRC     = 4,
    parameter int  MAX_BEATS = 16,
    localparam int SHIFT_W   = clog2(BUS_WIDTH / 8),
    localparam int ID_W      = clog2(N_SRC)
) (
    input  logic                       aclk,
    input  logic                       ARESET,
    input  logic [N_SRC*BUS_WIDTH-1:0] s_tdata,
    input  logic [N_SRC-1:0]           s_tvalid,
    input  logic [N_SRC-1:0]           s_tlast,
    output logic [N_SRC-1:0]           s_tready,
    output logic [BUS_WIDTH-1:0]       m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [SHIFT_W-1:0]         m_shift_bytes,
    output logic [ID_W-1:0]            m_src_id,
    input  logic                       cfg_we,
    input  logic [ID_W-1:0]            cfg_addr,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    output logic                       err_overlen,
    output logic                       busy
);

    localparam int CNT_W = clog2(MAX_BEATS + 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    gnt_q, gnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [SHIFT_W-1:0] shift_tab_q [N_SRC];

    logic [BUS_WIDTH-1:0] slice [N_SRC];
    logic [ID_W-1:0]      pick_gnt;
    logic                 pick_any;
    logic                 cur_valid, cur_last, last_beat;

    for (genvar i = 0; i < N_SRC; i++) begin : g_slice
        assign slice[i] = s_tdata[i*BUS_WIDTH +: BUS_WIDTH];
    end

    axis_rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
        .req_i   (s_tvalid),
        .ptr_i   (rr_q),
        .grant_o (pick_gnt),
        .any_o   (pick_any)
    );

    assign cur_valid = s_tvalid[gnt_q];
    assign cur_last  = s_tlast[gnt_q];
    // Next accepted beat is beat number MAX_BEATS of the packet.
    assign last_beat = (cnt_q == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    // Table read uses the registered value, so a same-cycle
                    // cfg write to this entry only affects later packets.
                    state_d = ST_XFER;
                    gnt_d   = pick_gnt;
                    rr_d    = pick_gnt;
                    shift_d = shift_tab_q[pick_gnt];
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                m_tdata         = slice[gnt_q];
                m_tvalid        = cur_valid;
                m_tlast         = cur_last | last_beat;
                s_tready[gnt_q] = m_tready;
                if (cur_valid && m_tready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cur_last) begin
                        state_d = ST_IDLE;
                    end else if (last_beat) begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                // Swallow the tail of an over-length packet.
                s_tready[gnt_q] = 1'b1;
                if (cur_valid && cur_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A beat presented while reset is held must not complete.
        if (ARESET) begin
            m_tdata  = '0;
            m_tvalid = 1'b0;
            m_tlast  = 1'b0;
            s_tready = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            rr_q    <= ID_W'(N_SRC - 1);
            gnt_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_SRC; i++) shift_tab_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (cfg_we && (int'(cfg_addr) < N_SRC)) shift_tab_q[cfg_addr] <= cfg_shift;
        end
    end

    assign m_shift_bytes = shift_q;
    assign m_src_id      = gnt_q;
    assign err_overlen   = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_shift_arbiter.sv
module tb_axis_shift_arbiter;

    logic         aclk = 1'b0;
    logic         ARESET;
    logic [127:0] s_tdata;
    logic [3:0]   s_tvalid, s_tlast, s_tready;
    logic [31:0]  m_tdata;
    logic         m_tvalid, m_tlast, m_tready;
    logic [1:0]   m_shift_bytes, m_src_id;
    logic         cfg_we;
    logic [1:0]   cfg_addr, cfg_shift;
    logic         err_overlen, busy;

    axis_shift_arbiter #(.BUS_WIDTH(32), .N_SRC(4), .MAX_BEATS(16)) dut (
        .aclk(aclk), .ARESET(ARESET),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .m_shift_bytes(m_shift_bytes), .m_src_id(m_src_id),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift),
        .err_overlen(err_overlen), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int drop_cyc;

    // source model: remaining beats, beat index, packet length, auto-repeat
    int rem [4];
    int bidx[4];
    int plen[4];
    bit rep [4];
    bit rdy_mode;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // shifter-side beat log
    int          lg_n;
    int          lg_src [64];
    logic [31:0] lg_dat [64];
    int          lg_last[64];
    int          lg_sh  [64];
    int          lg_cyc [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int i, input int b);
        logic [31:0] base;
        base = 32'h11111111 * 32'(b + 1);
        return base ^ (32'(i) << 28);
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]         = (rem[i] != 0);
            s_tlast[i]          = (rem[i] == 1);
            s_tdata[i*32 +: 32] = beat_data(i, bidx[i]);
        end
        #1;
    endtask

    task automatic start(input int i, input int len);
        rem[i]  = len;
        plen[i] = len;
        bidx[i] = 0;
        drive();
    endtask

    task automatic tick();
        logic [3:0] hs;
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready && lg_n < 64) begin
            lg_src[lg_n]  = int'(m_src_id);
            lg_dat[lg_n]  = m_tdata;
            lg_last[lg_n] = int'(m_tlast);
            lg_sh[lg_n]   = int'(m_shift_bytes);
            lg_cyc[lg_n]  = cyc;
            lg_n++;
        end
        if (busy && !m_tvalid && ((s_tready & s_tvalid) != 4'b0)) drop_cyc++;
        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                bidx[i]++;
                rem[i]--;
                if (rem[i] == 0 && rep[i]) begin
                    rem[i]  = plen[i];
                    bidx[i] = 0;
                end
            end
        end
        if (rdy_mode) m_tready = pat[cyc % 4];
        drive();
    endtask

    function automatic bit srcs_idle();
        return (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (rem[3] == 0);
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(srcs_idle() && !busy) && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 2000), 64'd1);
    endtask

    task automatic cfg_write(input int a, input int v);
        cfg_we    = 1'b1;
        cfg_addr  = 2'(a);
        cfg_shift = 2'(v);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            rep[i] = 1'b0;
            bidx[i] = 0;
        end
        drive();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        ARESET   = 1'b0;
        #1;
        lg_n     = 0;
        drop_cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1; m_tready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0;
        rdy_mode = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0;
        do_reset();

        // reset state
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mlast",  64'(m_tlast), 64'd0);
        chk("rst_mdata",  64'(m_tdata), 64'd0);
        chk("rst_sready", 64'(s_tready), 64'd0);
        chk("rst_srcid",  64'(m_src_id), 64'd0);
        chk("rst_shift",  64'(m_shift_bytes), 64'd0);
        chk("rst_err",    64'(err_overlen), 64'd0);

        // sources 0 and 2 together: 0 first, one bubble, then 2
        start(0, 2);
        start(2, 2);
        chk("t1_idle_mvalid", 64'(m_tvalid), 64'd0);
        chk("t1_idle_sready", 64'(s_tready), 64'd0);
        tick();
        chk("t1_gnt0_id",     64'(m_src_id), 64'd0);
        chk("t1_gnt0_sready", 64'(s_tready), 64'b0001);
        chk("t1_gnt0_data",   64'(m_tdata), 64'h11111111);
        drain("t1_drain");
        chk("t1_nbeats", 64'(lg_n), 64'd4);
        chk("t1_last1",  64'(lg_last[1]), 64'd1);
        chk("t1_src2",   64'(lg_src[2]), 64'd2);
        chk("t1_dat2",   64'(lg_dat[2]), 64'h31111111);
        chk("t1_bubble", 64'(lg_cyc[2] - lg_cyc[1]), 64'd2);

        // all four sources, continuous 3-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) rep[i] = 1'b1;
        for (int i = 0; i < 4; i++) start(i, 3);
        begin
            int n;
            n = 0;
            while (lg_n < 15 && n < 500) begin
                tick();
                n++;
            end
        end
        for (int i = 0; i < 4; i++) rep[i] = 1'b0;
        drain("t2_drain");
        chk("t2_ord0", 64'(lg_src[0]),  64'd0);
        chk("t2_ord1", 64'(lg_src[3]),  64'd1);
        chk("t2_ord2", 64'(lg_src[6]),  64'd2);
        chk("t2_ord3", 64'(lg_src[9]),  64'd3);
        chk("t2_ord4", 64'(lg_src[12]), 64'd0);
        chk("t2_round_span", 64'(lg_cyc[12] - lg_cyc[0]), 64'd16);
        chk("t2_b11_src", 64'(lg_src[11]), 64'd3);
        chk("t2_b11_last", 64'(lg_last[11]), 64'd1);

        // shift table: mid-packet write and same-cycle-as-grant write
        do_reset();
        cfg_write(1, 3);
        start(1, 4);
        tick();
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_shift = 2'd1;
        tick();
        cfg_we = 1'b0;
        drain("t3_drain_a");
        chk("t3_sh_b0", 64'(lg_sh[0]), 64'd3);
        chk("t3_sh_b3", 64'(lg_sh[3]), 64'd3);
        chk("t3_src",   64'(lg_src[3]), 64'd1);
        start(1, 1);
        drain("t3_drain_b");
        chk("t3_sh_next", 64'(lg_sh[4]), 64'd1);
        cfg_write(2, 2);
        start(2, 1);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_shift = 2'd3;
        tick();
        cfg_we = 1'b0;
        drain("t3_drain_c");
        chk("t3_sh_samecyc", 64'(lg_sh[5]), 64'd2);
        start(2, 1);
        drain("t3_drain_d");
        chk("t3_sh_after", 64'(lg_sh[6]), 64'd3);

        // exactly MAX_BEATS with tlast on the last one: normal end
        do_reset();
        start(0, 16);
        drain("t4_drain_a");
        chk("t4_exact_n",    64'(lg_n), 64'd16);
        chk("t4_exact_last", 64'(lg_last[15]), 64'd1);
        chk("t4_exact_err",  64'(err_overlen), 64'd0);
        chk("t4_exact_drop", 64'(drop_cyc), 64'd0);

        // 20-beat packet: cut at 16, 4 beats dropped
        lg_n = 0;
        drop_cyc = 0;
        start(3, 20);
        drain("t4_drain_b");
        chk("t4_long_n",     64'(lg_n), 64'd16);
        chk("t4_long_b15",   64'(lg_last[14]), 64'd0);
        chk("t4_long_b16",   64'(lg_last[15]), 64'd1);
        chk("t4_long_dat16", 64'(lg_dat[15]), 64'h21111110);
        chk("t4_long_err",   64'(err_overlen), 64'd1);
        chk("t4_long_drop",  64'(drop_cyc), 64'd4);
        chk("t4_long_busy",  64'(busy), 64'd0);

        // back-pressure 1,0,0,1
        do_reset();
        rdy_mode = 1'b1;
        start(0, 4);
        drain("t5_drain");
        rdy_mode = 1'b0;
        m_tready = 1'b1;
        chk("t5_n",  64'(lg_n), 64'd4);
        chk("t5_d0", 64'(lg_dat[0]), 64'h11111111);
        chk("t5_d1", 64'(lg_dat[1]), 64'h22222222);
        chk("t5_d2", 64'(lg_dat[2]), 64'h33333333);
        chk("t5_d3", 64'(lg_dat[3]), 64'h44444444);

        // reset on beat 2 of 5
        do_reset();
        start(0, 5);
        tick();
        tick();
        chk("t6_pre_n", 64'(lg_n), 64'd1);
        ARESET = 1'b1;
        #1;
        chk("t6_rst_mvalid", 64'(m_tvalid), 64'd0);
        tick();
        chk("t6_busy",   64'(busy), 64'd0);
        chk("t6_sready", 64'(s_tready), 64'd0);
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        drive();
        chk("t6_no_more", 64'(lg_n), 64'd1);
        start(0, 1);
        start(1, 1);
        drain("t6_drain");
        chk("t6_first", 64'(lg_src[1]), 64'd0);
        chk("t6_second", 64'(lg_src[2]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
